// File: rtl/compute_cluster_out_drain_pkg.sv
// Shared types and width constants for the compute-cluster output drain.
// Widths follow the cluster-wide build macros, with standalone defaults.
`ifndef COMPUTE_UNIT_NUM
`define COMPUTE_UNIT_NUM 4
`endif
`ifndef OUTPUT_BUF_NUM
`define OUTPUT_BUF_NUM 4
`endif
`ifndef OUTPUT_BUF_SIZE
`define OUTPUT_BUF_SIZE 16
`endif

package compute_cluster_out_drain_pkg;

  localparam int OD_CU_NUM  = `COMPUTE_UNIT_NUM;
  localparam int OD_BUF_NUM = `OUTPUT_BUF_NUM;
  localparam int OD_DAT_W   = `OUTPUT_BUF_SIZE;
  localparam int OD_CU_W    = (OD_CU_NUM > 1) ? $clog2(OD_CU_NUM) : 1;
  localparam int OD_BUF_W   = (OD_BUF_NUM > 1) ? $clog2(OD_BUF_NUM) : 1;
  localparam int OD_NUM_W   = $clog2(OD_BUF_NUM) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } drain_state_t;

  typedef struct packed {
    logic                last;
    logic [OD_CU_W-1:0]  cu;
    logic [OD_BUF_W-1:0] buf_idx;
  } beat_tag_t;

  localparam int OD_TAG_W = $bits(beat_tag_t);

endpackage

// File: rtl/compute_cluster_out_drain_if.sv
// Valid/ready result stream leaving the output drain.
interface compute_cluster_out_drain_if;
  import compute_cluster_out_drain_pkg::*;

  logic                out_valid;
  logic                out_ready;
  logic [OD_DAT_W-1:0] out_dat;
  logic [OD_CU_W-1:0]  out_cu_idx;
  logic [OD_BUF_W-1:0] out_buf_idx;
  logic                out_last;

  modport master (
    output out_valid, out_dat, out_cu_idx, out_buf_idx, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_dat, out_cu_idx, out_buf_idx, out_last,
    output out_ready
  );

endinterface

// File: rtl/compute_cluster_out_drain_fifo.sv
// Small synchronous FIFO for captured beats; head reads as zero while empty.
module compute_cluster_out_drain_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_dat_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             head_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             full, pop_ok, push_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty_o = (count == '0);
  assign count_o = count;
  assign pop_ok  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot a push on a full FIFO lands in.
  assign push_ok = push_i && (!full || pop_ok);
  assign head_o  = empty_o ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= push_dat_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/compute_cluster_out_drain.sv
// Walks every compute unit's output buffers CU-major, captures the read data after
// RD_LAT cycles and streams it out; issue is credit-limited so the FIFO never overflows.
module compute_cluster_out_drain
  import compute_cluster_out_drain_pkg::*;
#(
  parameter int CU_NUM  = OD_CU_NUM,
  parameter int BUF_NUM = OD_BUF_NUM,
  parameter int DAT_W   = OD_DAT_W,
  parameter int RD_LAT  = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                drain_start_i,
  input  logic [OD_NUM_W-1:0] drain_buf_num_i,
  output logic                drain_busy_o,
  output logic                drain_done_o,
  output logic [OD_CU_W-1:0]  com_unit_out_buf_sel_o,
  output logic [OD_BUF_W-1:0] out_buf_sel_o,
  input  logic [DAT_W-1:0]    out_buf_dat_i,
  compute_cluster_out_drain_if.master strm
);

  localparam int DEPTH = RD_LAT + 1;
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int ENT_W = DAT_W + OD_TAG_W;

  drain_state_t        state;
  logic [OD_CU_W-1:0]  cu_cnt;
  logic [OD_BUF_W-1:0] buf_cnt;
  logic [OD_NUM_W-1:0] num_q;
  logic                busy_q, done_q;

  beat_tag_t           tag_p [RD_LAT];
  logic [RD_LAT-1:0]   vld_p;

  logic [CNT_W-1:0]    inflight, fifo_cnt;
  logic [ENT_W-1:0]    head;
  beat_tag_t           head_tag;
  logic                fifo_empty, pop, credit_ok, issue, buf_end, last_sel;

  assign buf_end  = (OD_NUM_W'(buf_cnt) + OD_NUM_W'(1) == num_q);
  assign last_sel = buf_end && (cu_cnt == OD_CU_W'(CU_NUM-1));
  assign inflight = CNT_W'($countones(vld_p));
  assign pop      = !fifo_empty && strm.out_ready;
  // A beat leaving the FIFO this cycle returns its slot, keeping 1 beat/cycle with ready high.
  assign credit_ok = (int'(inflight) + int'(fifo_cnt)) < (DEPTH + int'(pop));
  assign issue     = (state == ISSUE) && credit_ok;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cu_cnt  <= '0;
      buf_cnt <= '0;
      num_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (drain_start_i) begin
            num_q <= (drain_buf_num_i > OD_NUM_W'(BUF_NUM)) ? OD_NUM_W'(BUF_NUM) : drain_buf_num_i;
            if (drain_buf_num_i == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state  <= ISSUE;
              busy_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (issue) begin
            if (last_sel) begin
              state <= FLUSH;
            end else if (buf_end) begin
              buf_cnt <= '0;
              cu_cnt  <= cu_cnt + OD_CU_W'(1);
            end else begin
              buf_cnt <= buf_cnt + OD_BUF_W'(1);
            end
          end
        end
        FLUSH: begin
          if (pop && head_tag.last) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          done_q  <= 1'b0;
          cu_cnt  <= '0;
          buf_cnt <= '0;
        end
      endcase
    end
  end

  // Stage p0..p(RD_LAT-1): tag travels alongside the outstanding buffer read
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    tag_p[0] <= '{last: last_sel, cu: cu_cnt, buf_idx: buf_cnt};
    for (int i = 1; i < RD_LAT; i++) tag_p[i] <= tag_p[i-1];
  end

  // Capture stage: read data joins its tag in the output FIFO
  compute_cluster_out_drain_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (vld_p[RD_LAT-1]),
    .push_dat_i ({tag_p[RD_LAT-1], out_buf_dat_i}),
    .pop_i      (pop),
    .head_o     (head),
    .empty_o    (fifo_empty),
    .count_o    (fifo_cnt)
  );

  assign head_tag = beat_tag_t'(head[ENT_W-1:DAT_W]);

  assign strm.out_valid   = !fifo_empty;
  assign strm.out_dat     = head[DAT_W-1:0];
  assign strm.out_cu_idx  = head_tag.cu;
  assign strm.out_buf_idx = head_tag.buf_idx;
  assign strm.out_last    = head_tag.last;

  assign drain_busy_o           = busy_q;
  assign drain_done_o           = done_q;
  assign com_unit_out_buf_sel_o = cu_cnt;
  assign out_buf_sel_o          = buf_cnt;

endmodule
